// File: rtl/mac_sm_vec_pkg.sv
// Shared types and sign-magnitude / two's-complement helpers for the mac_sm_vec engine.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int unsigned W_DEF     = 16;
  localparam int unsigned FRAC_DEF  = 12;
  localparam int unsigned LEN_W_DEF = 8;
  // Common working width for the helpers so they serve any W/LEN_W up to 64 bits.
  localparam int unsigned XW        = 64;

  function automatic logic signed [XW-1:0] sm_to_tc(input logic sign, input logic [XW-1:0] mag);
    logic signed [XW-1:0] m;
    m = $signed(mag);
    return sign ? -m : m;
  endfunction

  // Result occupies bits w-1:0; magnitude clamps to 2^(w-1)-1 and zero never carries a sign.
  function automatic logic [XW-1:0] tc_to_sm_sat(input logic signed [XW-1:0] v, input int unsigned w);
    logic            neg;
    logic [XW-1:0]   mag;
    logic [XW-1:0]   lim;
    neg = v[XW-1];
    mag = neg ? XW'(-v) : XW'(v);
    lim = (XW'(1) << (w - 1)) - XW'(1);
    if (mag > lim) mag = lim;
    if (mag == '0) return '0;
    return (XW'(neg) << (w - 1)) | mag;
  endfunction

endpackage

// File: rtl/mac_sm_vec_if.sv
// Operand stream, control and result handshake bundle for mac_sm_vec.
interface mac_sm_vec_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned LEN_W = 8
) ();
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic             busy;

  modport slave  (input  start, len, in_valid, a, b, out_ready,
                  output in_ready, out_valid, out, busy);
  modport master (output start, len, in_valid, a, b, out_ready,
                  input  in_ready, out_valid, out, busy);
endinterface

// File: rtl/mac_sm_vec_sm_mul.sv
// Combinational sign-magnitude fixed-point multiply with scale and saturation.
// MAC_ROUND_EN: round half away from zero before the shift; otherwise truncate.
module sm_mul
  import mac_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         sign_c,
  output logic [W-2:0] mag_c
);
  localparam int unsigned MW = W - 1;
  localparam int unsigned PW = 2 * W - 2;
  localparam int unsigned RW = 2 * W - 1;

  logic [PW-1:0] prod;
  logic [RW-1:0] prod_r;
  logic [RW-1:0] scaled;

  always_comb begin
    prod = PW'(a[W-2:0]) * PW'(b[W-2:0]);
`ifdef MAC_ROUND_EN
    prod_r = RW'(prod) + (RW'(1) << (FRAC - 1));
`else
    prod_r = RW'(prod);
`endif
    scaled = prod_r >> FRAC;
    if (|scaled[RW-1:MW]) mag_c = '1;
    else                  mag_c = scaled[MW-1:0];
    // Zero magnitude (including negative-zero inputs) always yields +0.
    sign_c = (a[W-1] ^ b[W-1]) & (|mag_c);
  end
endmodule

// File: rtl/mac_sm_vec.sv
// Streaming sign-magnitude dot-product engine: 2-stage multiply/accumulate with saturating output.
// Optional MAC_ROUND_EN selects rounding in the multiplier.
module mac_sm_vec
  import mac_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned FRAC  = FRAC_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  mac_sm_vec_if.slave  bus
);
  localparam int unsigned ACC_W = W + LEN_W;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [W-1:0]             out_q, out_d;
  logic                     busy_q, busy_d;
  logic                     p1_valid_q, p1_valid_d;
  logic                     p1_sign_q, p1_sign_d;
  logic [W-2:0]             p1_mag_q, p1_mag_d;
  logic                     p2_valid_q, p2_valid_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic                     mul_sign_c;
  logic [W-2:0]             mul_mag_c;
  logic                     xfer_c;

  sm_mul #(.W(W), .FRAC(FRAC)) u_mul (
    .a      (bus.a),
    .b      (bus.b),
    .sign_c (mul_sign_c),
    .mag_c  (mul_mag_c)
  );

  assign xfer_c = bus.in_valid && in_ready_q && (state_q == RUN);

  // Next-state, pipeline and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready_q;
    out_d      = out_q;
    p1_valid_d = xfer_c;
    p1_sign_d  = xfer_c ? mul_sign_c : p1_sign_q;
    p1_mag_d   = xfer_c ? mul_mag_c  : p1_mag_q;
    p2_valid_d = p1_valid_q;
    acc_d      = p1_valid_q ? acc_q + ACC_W'(sm_to_tc(p1_sign_q, XW'(p1_mag_q))) : acc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d = bus.len;
          acc_d = '0;
          if (bus.len == '0) begin
            state_d = DONE;
            out_d   = '0;
          end else begin
            state_d    = RUN;
            in_ready_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer_c) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d    = DRAIN;
            in_ready_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (!p1_valid_q && !p2_valid_q) begin
          state_d = DONE;
          out_d   = W'(tc_to_sm_sat(XW'(acc_q), W));
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_sign_q   <= 1'b0;
      p1_mag_q    <= '0;
      p2_valid_q  <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      p1_valid_q  <= p1_valid_d;
      p1_sign_q   <= p1_sign_d;
      p1_mag_q    <= p1_mag_d;
      p2_valid_q  <= p2_valid_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mac_sm_vec.sv
// Scoreboard bench for mac_sm_vec: directed vectors, monitor pops expected results on handshake.
module tb_mac_sm_vec;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_sm_vec_if #(.W(16), .LEN_W(8)) bus ();
  mac_sm_vec dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] va[4];
  logic [15:0] vb[4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: compares at the sampling point preceding each accepted handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got 0x%04h expected none", bus.out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.out !== e) begin
          bad++;
          $display("FAIL result: got 0x%04h expected 0x%04h", bus.out, e);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    check({name, "_idle"}, 16'(bus.busy), 16'h0);
  endtask

  task automatic start_vec(input int n);
    bus.start = 1'b1;
    bus.len   = 8'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input string name, input int n, input logic [15:0] exp, input bit chk_timing);
    exp_q.push_back(exp);
    start_vec(n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.a = va[i];
      bus.b = vb[i];
      tick();
    end
    bus.in_valid = 1'b0;
    if (chk_timing) begin
      check({name, "_in_ready_low"}, 16'(bus.in_ready), 16'h0);
      tick();
      tick();
      check({name, "_out_valid_early"}, 16'(bus.out_valid), 16'h0);
      tick();
      check({name, "_out_valid_on_time"}, 16'(bus.out_valid), 16'h1);
    end
    wait_idle(name);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready",  16'(bus.in_ready),  16'h0);
    check("rst_out_valid", 16'(bus.out_valid), 16'h0);
    check("rst_out",       bus.out,            16'h0);
    check("rst_busy",      16'(bus.busy),      16'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin va[i] = 16'h1000; vb[i] = 16'h1000; end
    run_vec("ones4", 4, 16'h4000, 1'b1);

    va[0] = 16'h1000; vb[0] = 16'h9800; va[1] = 16'h2000; vb[1] = 16'h2000;
    run_vec("mixed", 2, 16'h2800, 1'b0);
    va[0] = 16'h2000; vb[0] = 16'h2000; va[1] = 16'h1000; vb[1] = 16'h9800;
    run_vec("mixed_swap", 2, 16'h2800, 1'b0);

    va[0] = 16'h7000; vb[0] = 16'h7000; va[1] = 16'h7000; vb[1] = 16'h7000;
    run_vec("sat_pos", 2, 16'h7FFF, 1'b1);
    va[0] = 16'hF000; vb[0] = 16'h7000; va[1] = 16'hF000; vb[1] = 16'h7000;
    run_vec("sat_neg", 2, 16'hFFFF, 1'b0);

    va[0] = 16'h8000; vb[0] = 16'h1000;
    run_vec("neg_zero", 1, 16'h0000, 1'b0);

    exp_q.push_back(16'h0000);
    start_vec(0);
    check("len0_out_valid", 16'(bus.out_valid), 16'h1);
    wait_idle("len0");

    // Input gap mid-vector plus a 3-cycle output stall.
    exp_q.push_back(16'h3000);
    bus.out_ready = 1'b0;
    start_vec(3);
    bus.in_valid = 1'b1; bus.a = 16'h1000; bus.b = 16'h1000; tick();
    bus.in_valid = 1'b0; bus.a = 16'h7FFF; bus.b = 16'h7FFF; tick(); tick();
    bus.in_valid = 1'b1; bus.a = 16'h1000; bus.b = 16'h1000; tick(); tick();
    bus.in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 20) begin tick(); n++; end
    end
    for (int i = 0; i < 3; i++) begin
      check("stall_out_valid", 16'(bus.out_valid), 16'h1);
      check("stall_out",       bus.out,            16'h3000);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle("stall");

    // Reset in the middle of a run.
    start_vec(4);
    bus.in_valid = 1'b1; bus.a = 16'h1000; bus.b = 16'h1000; tick(); tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_in_ready",  16'(bus.in_ready),  16'h0);
    check("midrst_out_valid", 16'(bus.out_valid), 16'h0);
    check("midrst_out",       bus.out,            16'h0);
    check("midrst_busy",      16'(bus.busy),      16'h0);
    rst_n = 1'b1;
    tick();
    va[0] = 16'h1000; vb[0] = 16'h1000;
    run_vec("post_rst", 1, 16'h1000, 1'b1);

    va[0] = 16'h0001; vb[0] = 16'h0800;
`ifdef MAC_ROUND_EN
    run_vec("round", 1, 16'h0001, 1'b0);
`else
    run_vec("round", 1, 16'h0000, 1'b0);
`endif

    tick(); tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL results_pending: got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
